hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Parameters
REQ-001 SHALL provide FORWARDING, default 1: 1 = EX-stage forwarding present; 0 = no forwarding.
REQ-002 SHALL provide RF_BYPASS, default 0: 1 = register file returns the same-cycle write; 0 = it does not.
REQ-003 SHALL provide MAX_STALL, default 7: the stall run length above which a timeout is flagged.

Interface
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
REQ-005 SHALL have ID-stage source inputs:
- id_rs  in  5  rs field of the instruction in IF/ID
- id_rt  in  5  rt field of the instruction in IF/ID
- id_uses_rt  in  1  instruction reads rt as a source
REQ-006 SHALL have EX-stage inputs:
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_reg_write  in  1  ID/EX instruction writes a register
- ex_dest  in  5  ID/EX destination register
REQ-007 SHALL have MEM- and WB-stage inputs:
- mem_reg_write  in  1  EX/MEM instruction writes a register
- mem_dest  in  5  EX/MEM destination register
- wb_reg_write  in  1  MEM/WB instruction writes a register
- wb_dest  in  5  MEM/WB destination register
REQ-008 SHALL have a redirect input:
- redirect  in  1  taken branch, jump or jr resolved in MEM this cycle
REQ-009 SHALL have pipeline-control outputs:
- pc_en  out  1  PC load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID at next edge
- id_ex_flush  out  1  clear ID/EX at next edge (bubble)
- ex_mem_flush  out  1  clear EX/MEM at next edge
REQ-010 SHALL have status outputs:
- state  out  2  RUN=0, STALL=1, FLUSH=2
- stall_cnt  out  16  total stall cycles
- flush_cnt  out  16  total redirects
- stall_timeout  out  1  sticky error flag

Function
REQ-011 A match SHALL be (id_rs==X) or (id_uses_rt and id_rt==X), with X≠0; register 0 never matches.
REQ-012 With FORWARDING=1, hazard SHALL be ex_mem_read and a match on ex_dest.
REQ-013 With FORWARDING=0, hazard SHALL be (ex_reg_write, ex_dest) match or (mem_reg_write, mem_dest) match.
REQ-014 With FORWARDING=0 and RF_BYPASS=0, hazard SHALL also include a (wb_reg_write, wb_dest) match.
REQ-015 Control outputs SHALL be combinational from the current inputs, with 0 cycles of latency.
REQ-016 When redirect=1, outputs SHALL be: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
REQ-017 Redirect SHALL take priority over hazard; a simultaneous hazard is discarded and not counted as a stall.
REQ-018 When hazard=1 and redirect=0, outputs SHALL be: pc_en=0, if_id_en=0, id_ex_flush=1, and both other flushes 0.
REQ-019 Otherwise, outputs SHALL be: pc_en=1, if_id_en=1, and all flushes 0.
REQ-020 The state register SHALL load FLUSH if redirect, else STALL if hazard, else RUN, on every rising clk edge.
REQ-021 The state value SHALL be informational only and SHALL NOT feed back into the control outputs.
REQ-022 stall_cnt SHALL increment per STALL-class cycle (REQ-018 condition) and saturate at 0xFFFF.
REQ-023 flush_cnt SHALL increment per redirect cycle and saturate at 0xFFFF.
REQ-024 An internal run counter SHALL count consecutive STALL-class cycles and clear on any other cycle.
REQ-025 stall_timeout SHALL set on the edge where the run counter would exceed MAX_STALL, and SHALL then stay set until reset.
REQ-026 Boundary: a hazard present in consecutive cycles SHALL stall every cycle it persists; there is no limit other than flagging.

Reset
REQ-027 While reset=0, registers SHALL be asynchronously cleared: state=RUN, stall_cnt=0, flush_cnt=0, run counter=0, stall_timeout=0.
REQ-028 Control outputs SHALL remain combinational during reset; on the first edge after release, counting resumes from 0.
REQ-029 Reset asserted mid-stall SHALL discard the stall run without setting stall_timeout.

Verification
REQ-030 Load-use: FORWARDING=1, ex_mem_read=1, ex_dest=5, id_rs=5 for 1 cycle -> pc_en=0, id_ex_flush=1, state=STALL next, stall_cnt=1.
REQ-031 Zero register: ex_mem_read=1, ex_dest=0, id_rs=0 -> no stall, pc_en=1, stall_cnt unchanged.
REQ-032 Priority: redirect=1 with the REQ-030 hazard -> all three flushes 1, pc_en=1, flush_cnt=1, stall_cnt=0, state=FLUSH.
REQ-033 No forwarding: FORWARDING=0, RF_BYPASS=0, wb_reg_write=1, wb_dest=9, id_rt=9, id_uses_rt=1 -> stall. With id_uses_rt=0 -> no stall.
REQ-034 Timeout: hold the hazard for 8 cycles with MAX_STALL=7 -> stall_timeout=1 after the 8th edge; it stays 1 after the hazard clears. Reset -> 0.
REQ-035 Saturation/reset: preload by running 65536 stall cycles -> stall_cnt=0xFFFF. Then assert reset mid-stall -> all counters 0 and state=RUN immediately.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard detection and pipeline control for a 5-stage in-order pipeline.
// Stall/flush controls are combinational; state, counters and timeout are registered.
module hazard_controller #(
  parameter int FORWARDING = 1,
  parameter int RF_BYPASS  = 0,
  parameter int MAX_STALL  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dest,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_dest,
  input  logic        redirect,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic        FWD       = (FORWARDING != 0);
  localparam logic        WB_HAZ    = (RF_BYPASS == 0);
  localparam logic [16:0] RUN_LIMIT = 17'(MAX_STALL);

  function automatic logic src_match(input logic [4:0] dest, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dest != 5'd0) && ((rs == dest) || (uses_rt && (rt == dest)));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q;
  logic [15:0] run_cnt;
  logic        ex_hit, mem_hit, wb_hit;
  logic        fwd_hazard, nofwd_hazard, hazard, stall_cycle;

  always_comb begin
    ex_hit       = src_match(ex_dest, id_rs, id_rt, id_uses_rt);
    mem_hit      = src_match(mem_dest, id_rs, id_rt, id_uses_rt);
    wb_hit       = src_match(wb_dest, id_rs, id_rt, id_uses_rt);
    // Only a load in EX can hurt when results are forwarded from EX/MEM onward.
    fwd_hazard   = ex_mem_read && ex_hit;
    nofwd_hazard = (ex_reg_write && ex_hit) || (mem_reg_write && mem_hit) ||
                   (WB_HAZ && wb_reg_write && wb_hit);
    hazard       = FWD ? fwd_hazard : nofwd_hazard;
    stall_cycle  = hazard && !redirect;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_cnt     <= 16'd0;
      flush_cnt     <= 16'd0;
      run_cnt       <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      if (redirect)    state_q <= FLUSH;
      else if (hazard) state_q <= STALL;
      else             state_q <= RUN;

      if (redirect) flush_cnt <= sat_inc(flush_cnt);

      // Timeout fires on the edge that takes the run past MAX_STALL.
      if (stall_cycle) begin
        stall_cnt <= sat_inc(stall_cnt);
        run_cnt   <= sat_inc(run_cnt);
        if ({1'b0, run_cnt} >= RUN_LIMIT) stall_timeout <= 1'b1;
      end else begin
        run_cnt <= 16'd0;
      end
    end
  end

endmodule
